axi_rd_slave: RTL and testbench
===============================

AXI_RD_SLAVE -- requirements
Module: axi_rd_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32: RDATA and memory word width.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32: ARADDR width.
REQ-003 SHALL have parameter C_S_AXI_ID_WIDTH, default 1: ARID/RID width.
REQ-004 SHALL have parameter MEM_DEPTH, default 256: number of memory words, power of two.
REQ-005 SHALL have port S_AXI_ACLK, in, 1: the single clock; every flop is on its rising edge.
REQ-006 SHALL have port S_AXI_ARESET, in, 1: asynchronous, active-high reset.
REQ-007 SHALL have port wr_en, in, 1: preload-write strobe.
REQ-008 SHALL have port wr_addr, in, log2(MEM_DEPTH): preload word index.
REQ-009 SHALL have port wr_dat, in, C_S_AXI_DATA_WIDTH: preload data.
REQ-010 SHALL have AR ports S_AXI_ARID/ARADDR/ARLEN(8)/ARSIZE(3)/ARBURST(2)/ARVALID as inputs and S_AXI_ARREADY as an output.
REQ-011 SHALL have R ports S_AXI_RID/RDATA/RRESP(2)/RLAST/RVALID as outputs and S_AXI_RREADY as an input.
REQ-012 SHALL have port busy, out, 1: high while in BURST.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and BURST, with one outstanding transaction at most.
REQ-014 SHALL drive ARREADY=1 exactly when in IDLE (registered); on ARVALID&&ARREADY it SHALL latch ARID, the word address ARADDR>>log2(DATA_WIDTH/8) (low bits discarded), ARLEN, and ARBURST, then enter BURST.
REQ-015 SHALL assert RVALID for the first beat in the cycle after the AR handshake (latency 1).
REQ-016 SHALL return exactly ARLEN+1 beats and assert RLAST on the final beat only; RID SHALL equal the latched ARID on every beat.
REQ-017 SHALL hold RDATA/RRESP/RLAST/RID/RVALID stable while RVALID&&!RREADY.
REQ-018 SHALL present the next beat in the cycle after each non-last R handshake, with no bubbles when RREADY stays high.
REQ-019 SHALL increment the word address by 1 per beat for INCR, modulo 2^(ADDR_WIDTH), and hold it constant for FIXED.
REQ-020 SHALL return RRESP=SLVERR (2'b10) with RDATA=0 for a beat whose word address is >= MEM_DEPTH; all other beats SHALL return OKAY (2'b00) with mem[addr].
REQ-021 SHALL answer a burst with SLVERR and RDATA=0 on every beat, keeping the full beat count and RLAST, when ARBURST is WRAP or reserved, or when ARSIZE != log2(DATA_WIDTH/8).
REQ-022 SHALL, on the last-beat handshake, deassert RVALID and RLAST, return to IDLE, and raise ARREADY in the following cycle.
REQ-023 SHALL write wr_dat into mem[wr_addr] at the clock edge when wr_en=1, in any state; a beat loaded at the same edge SHALL see the pre-write contents.
REQ-024 SHALL read memory combinationally and register it into RDATA.

Reset
REQ-025 SHALL, while S_AXI_ARESET=1, force ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RDATA=0, RID=0, busy=0, and state IDLE, asynchronously.
REQ-026 SHALL abandon any burst in progress on reset assertion without producing further beats, and SHALL NOT clear the memory contents.
REQ-027 SHALL raise ARREADY on the first clock edge after S_AXI_ARESET deasserts.

Structure
REQ-028 SHALL take the AXI widths and the RESP/BURST encodings (OKAY, SLVERR, FIXED, INCR, WRAP) from the shared define_axi.vh header.
REQ-029 SHALL use the team's existing logic_mem as its storage sub-module, or an internal array with identical write semantics.

Verification
REQ-030 Preload mem[i]=i+100 for i=0..15; AR addr 0x0, INCR, ARLEN=15, RREADY=1 -> 16 beats 100..115 on consecutive cycles, OKAY, RLAST on beat 16 only, first RVALID 1 cycle after AR handshake.
REQ-031 Same burst with RREADY toggled 1,0,0,1,... -> identical data sequence; outputs stable while stalled; no beat lost or duplicated.
REQ-032 FIXED burst, addr 0x8, ARLEN=3 -> 4 beats, all 102, RLAST on beat 4.
REQ-033 INCR burst, addr word 254, ARLEN=3, MEM_DEPTH=256 -> beats 254/255 OKAY with data; beats 256/257 SLVERR with data 0.
REQ-034 WRAP burst, ARLEN=1 -> 2 beats of SLVERR/0, RLAST on beat 2; also ARSIZE=1 -> the same SLVERR response.
REQ-035 Assert S_AXI_ARESET mid-burst at beat 5 -> RVALID=0 immediately; after release ARREADY=1; a new burst from addr 0 returns the preloaded data.

Source files
------------

// File: rtl/axi_rd_slave_pkg.sv
// rtl/axi_rd_slave_pkg.sv - shared AXI encodings and state type for the read slave
package axi_rd_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Only FIXED and INCR are served; WRAP and the reserved code get SLVERR.
    function automatic logic burst_supported(input logic [1:0] burst);
        return (burst == BURST_FIXED) || (burst == BURST_INCR);
    endfunction

endpackage

// File: rtl/axi_rd_slave_mem.sv
// rtl/axi_rd_slave_mem.sv - word memory with sync preload write and async read
module axi_rd_slave_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    // Contents are deliberately not reset so preloaded data survives a bus reset.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Preload write; a read in the same cycle sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/axi_rd_slave.sv
// rtl/axi_rd_slave.sv - single-outstanding AXI read slave backed by a preloadable memory
module axi_rd_slave
    import axi_rd_slave_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int MEM_DEPTH          = 256
) (
    input  logic                           S_AXI_ACLK,
    input  logic                           S_AXI_ARESET,
    input  logic                           wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0]   wr_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]  wr_dat,
    input  logic [C_S_AXI_ID_WIDTH-1:0]    S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]  S_AXI_ARADDR,
    input  logic [7:0]                     S_AXI_ARLEN,
    input  logic [2:0]                     S_AXI_ARSIZE,
    input  logic [1:0]                     S_AXI_ARBURST,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]    S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]  S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RLAST,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic                           busy
);

    localparam int AW        = C_S_AXI_ADDR_WIDTH;
    localparam int DW        = C_S_AXI_DATA_WIDTH;
    localparam int IDX_W     = $clog2(MEM_DEPTH);
    localparam int SIZE_LOG2 = $clog2(C_S_AXI_DATA_WIDTH / 8);

    state_t                state_q, state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DW-1:0]         rdata_q, rdata_d;
    logic [C_S_AXI_ID_WIDTH-1:0] rid_q, rid_d;
    logic [AW-1:0]         addr_q, addr_d;   // word address of the next beat to load
    logic [7:0]            cnt_q, cnt_d;     // beats still to load after the one on the bus
    logic [1:0]            burst_q, burst_d;
    logic                  err_q, err_d;     // whole burst is answered with SLVERR

    logic                  ar_hs;
    logic                  r_hs;
    logic [AW-1:0]         beat_addr;
    logic [AW-1:0]         beat_next;
    logic [1:0]            beat_burst;
    logic                  beat_err;
    logic                  beat_bad;
    logic [DW-1:0]         rd_dat;

    // The beat being loaded comes from the AR channel on the handshake, else from the burst registers.
    always_comb begin
        ar_hs      = S_AXI_ARVALID && arready_q;
        r_hs       = rvalid_q && S_AXI_RREADY;
        beat_addr  = ar_hs ? (S_AXI_ARADDR >> SIZE_LOG2) : addr_q;
        beat_burst = ar_hs ? S_AXI_ARBURST : burst_q;
        beat_err   = ar_hs ? (!burst_supported(S_AXI_ARBURST) || (S_AXI_ARSIZE != 3'(SIZE_LOG2)))
                           : err_q;
        beat_next  = (beat_burst == BURST_INCR) ? beat_addr + AW'(1) : beat_addr;
        beat_bad   = beat_err || (beat_addr[AW-1:IDX_W] != '0);
    end

    axi_rd_slave_mem #(
        .DATA_W (DW),
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk     (S_AXI_ACLK),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_dat  (wr_dat),
        .rd_addr (beat_addr[IDX_W-1:0]),
        .rd_dat  (rd_dat)
    );

    // Next-state and registered R/AR outputs: accept AR in IDLE, stream beats in BURST.
    always_comb begin
        state_d   = state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rid_d     = rid_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        burst_d   = burst_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d = 1'b0;
                    state_d   = ST_BURST;
                    burst_d   = S_AXI_ARBURST;
                    err_d     = beat_err;
                    rid_d     = S_AXI_ARID;
                    rvalid_d  = 1'b1;
                    rlast_d   = (S_AXI_ARLEN == 8'd0);
                    cnt_d     = S_AXI_ARLEN;
                    addr_d    = beat_next;
                    rresp_d   = beat_bad ? RESP_SLVERR : RESP_OKAY;
                    rdata_d   = beat_bad ? '0 : rd_dat;
                end
            end
            ST_BURST: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        state_d   = ST_IDLE;
                        arready_d = 1'b1;
                    end else begin
                        rlast_d = (cnt_q == 8'd1);
                        cnt_d   = cnt_q - 8'd1;
                        addr_d  = beat_next;
                        rresp_d = beat_bad ? RESP_SLVERR : RESP_OKAY;
                        rdata_d = beat_bad ? '0 : rd_dat;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any burst immediately.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q   <= ST_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rid_q     <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            burst_q   <= BURST_FIXED;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            rid_q     <= rid_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RID     = rid_q;
    assign busy          = (state_q == ST_BURST);

endmodule

// File: tb/tb_axi_rd_slave.sv
// tb/tb_axi_rd_slave.sv - scoreboard bench for the AXI read slave
module tb_axi_rd_slave;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        id;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_dat = '0;
    logic        arid = 1'b0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = 2'b01;
    logic        arvalid = 1'b0;
    logic        arready;
    logic        rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        busy;

    logic [31:0] model_mem [256];
    beat_t       sb [$];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    axi_rd_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_dat        (wr_dat),
        .S_AXI_ARID    (arid),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARLEN   (arlen),
        .S_AXI_ARSIZE  (arsize),
        .S_AXI_ARBURST (arburst),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RID     (rid),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RLAST   (rlast),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .busy          (busy)
    );

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        wr_en   = 1'b1;
        wr_addr = idx;
        wr_dat  = val;
        model_mem[idx] = val;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic expect_burst(input logic [31:0] start, input logic [7:0] len,
                                input logic [1:0] burst, input logic [2:0] size, input logic id);
        for (int i = 0; i <= int'(len); i++) begin
            logic [31:0] a;
            logic        bad;
            beat_t       b;
            a   = (burst == 2'b01) ? start + 32'(i) : start;
            bad = (burst > 2'b01) || (size != 3'd2) || (a >= 32'd256);
            b.data = bad ? 32'd0 : model_mem[a[7:0]];
            b.resp = bad ? 2'b10 : 2'b00;
            b.last = (i == int'(len));
            b.id   = id;
            sb.push_back(b);
        end
    endtask

    task automatic issue_ar(input string name, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic id);
        int w = 0;
        araddr  = addr;
        arlen   = len;
        arsize  = size;
        arburst = burst;
        arid    = id;
        arvalid = 1'b1;
        while (arready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        n_checks++;
        if (w >= 20 || rvalid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ar_latency: wait=%0d rvalid=%b busy=%b required rvalid=1 busy=1",
                     name, w, rvalid, busy);
        end
    endtask

    task automatic run_burst(input string name, input bit toggle);
        int          cyc = 0;
        int          n_exp = sb.size();
        int          got = 0;
        bit          done = 1'b0;
        bit          stalled = 1'b0;
        logic [36:0] held = '0;
        logic [36:0] now;
        beat_t       e;
        while (!done && cyc < 300) begin
            rready = toggle ? ((cyc % 3) == 0) : 1'b1;
            now = {rvalid, rlast, rid, rresp, rdata};
            if (stalled) begin
                n_checks++;
                if (now !== held) begin
                    n_fail++;
                    $display("FAIL %s stall_stable: got %h required %h", name, now, held);
                end
            end
            if (rvalid === 1'b1) begin
                if (rready) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s extra_beat: got data=%h with no beat expected", name, rdata);
                        done = 1'b1;
                    end else begin
                        e = sb.pop_front();
                        got++;
                        if ({rdata, rresp, rlast, rid} !== {e.data, e.resp, e.last, e.id}) begin
                            n_fail++;
                            $display("FAIL %s beat%0d: got data=%h resp=%b last=%b id=%b required data=%h resp=%b last=%b id=%b",
                                     name, got, rdata, rresp, rlast, rid, e.data, e.resp, e.last, e.id);
                        end
                        if (e.last) done = 1'b1;
                    end
                    stalled = 1'b0;
                end else begin
                    held    = now;
                    stalled = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        n_checks++;
        if (!done || got != n_exp) begin
            n_fail++;
            $display("FAIL %s beat_count: got %0d required %0d", name, got, n_exp);
        end
        if (!toggle) begin
            n_checks++;
            if (cyc != n_exp) begin
                n_fail++;
                $display("FAIL %s no_bubble: cycles %0d required %0d", name, cyc, n_exp);
            end
        end
        n_checks++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || arready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end_state: rvalid=%b rlast=%b arready=%b busy=%b required 0 0 1 0",
                     name, rvalid, rlast, arready, busy);
        end
        sb.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({arready, rvalid, rlast, rresp, rdata, rid, busy} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_state: arready=%b rvalid=%b rlast=%b rresp=%b rdata=%h rid=%b busy=%b required all 0",
                     arready, rvalid, rlast, rresp, rdata, rid, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (arready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: arready=%b busy=%b required 1 0", arready, busy);
        end
    endtask

    task automatic test_incr();
        expect_burst(32'd0, 8'd15, 2'b01, 3'd2, 1'b0);
        issue_ar("incr", 32'h0, 8'd15, 3'd2, 2'b01, 1'b0);
        run_burst("incr", 1'b0);
    endtask

    task automatic test_stall();
        expect_burst(32'd0, 8'd15, 2'b01, 3'd2, 1'b1);
        issue_ar("stall", 32'h0, 8'd15, 3'd2, 2'b01, 1'b1);
        run_burst("stall", 1'b1);
    endtask

    task automatic test_fixed();
        expect_burst(32'd2, 8'd3, 2'b00, 3'd2, 1'b0);
        issue_ar("fixed", 32'h8, 8'd3, 3'd2, 2'b00, 1'b0);
        run_burst("fixed", 1'b0);
    endtask

    task automatic test_oob();
        expect_burst(32'd254, 8'd3, 2'b01, 3'd2, 1'b1);
        issue_ar("oob", 32'd254 * 4, 8'd3, 3'd2, 2'b01, 1'b1);
        run_burst("oob", 1'b0);
    endtask

    task automatic test_wrap_size();
        expect_burst(32'd0, 8'd1, 2'b10, 3'd2, 1'b0);
        issue_ar("wrap", 32'h0, 8'd1, 3'd2, 2'b10, 1'b0);
        run_burst("wrap", 1'b0);
        expect_burst(32'd1, 8'd1, 2'b01, 3'd1, 1'b0);
        issue_ar("size", 32'h4, 8'd1, 3'd1, 2'b01, 1'b0);
        run_burst("size", 1'b1);
    endtask

    task automatic test_mid_reset();
        issue_ar("midrst", 32'h0, 8'd15, 3'd2, 2'b01, 1'b0);
        rready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== model_mem[k]) begin
                n_fail++;
                $display("FAIL midrst_beat%0d: rvalid=%b data=%h required 1 %h", k, rvalid, rdata, model_mem[k]);
            end
            @(negedge clk);
        end
        rready = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({arready, rvalid, rlast, rresp, rdata, rid, busy} !== 39'd0) begin
            n_fail++;
            $display("FAIL midrst_async: arready=%b rvalid=%b rlast=%b rdata=%h busy=%b required all 0",
                     arready, rvalid, rlast, rdata, busy);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b0 || arready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_held: rvalid=%b arready=%b required 0 0", rvalid, arready);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_release: arready=%b rvalid=%b required 1 0", arready, rvalid);
        end
        expect_burst(32'd0, 8'd3, 2'b01, 3'd2, 1'b1);
        issue_ar("after_rst", 32'h0, 8'd3, 3'd2, 2'b01, 1'b1);
        run_burst("after_rst", 1'b0);
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < 16; i++) preload(8'(i), 32'(i + 100));
        preload(8'd254, 32'hCAFE_0254);
        preload(8'd255, 32'hCAFE_0255);
        test_incr();
        test_stall();
        test_fixed();
        test_oob();
        test_wrap_size();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
